// File: rtl/bp_resolve_unit.sv
// -----------------------------------------------------------------------------
// bp_resolve_unit
//
// Producer side of the branch-predictor update interface. Every prediction
// issued at fetch is recorded in an in-order FIFO. When execute resolves a
// branch, the FIFO head is matched against the resolved PC. The unit then:
//   - emits a one-cycle training update (ex_br_*) for every resolution, and
//   - raises a one-cycle mispredict redirect to the front end when needed.
//
// Handshake: a prediction is accepted on a clock edge where pred_valid_i and
// pred_ready_o are both high. pred_ready_o does not depend on pred_valid_i.
// A push is still dropped, even when accepted, if the same cycle carries a
// mispredict or a flush, because that prediction is on the wrong path.
//
// Optional feature: define BP_STATS_EN to enable the saturating
// branch/mispredict counters. When it is undefined, both counter outputs are
// tied to zero.
//
// Ports
//   clk_i, rst_ni         clock and synchronous active-low reset
//   pred_*                prediction push from IF (pc, taken, target)
//   pred_ready_o          FIFO can accept a prediction this cycle
//   ex_*                  branch resolution from EX (pc, taken, target)
//   flush_i               external flush; clears the FIFO and suppresses the redirect
//   ex_br_*               registered training update (valid, addr, taken)
//   mispredict_o          registered one-cycle redirect strobe
//   redirect_pc_o         registered correct next PC
//   branch_cnt_o          resolved-branch count (BP_STATS_EN)
//   mispredict_cnt_o      mispredict count (BP_STATS_EN)
// -----------------------------------------------------------------------------
module bp_resolve_unit #(
  parameter int Depth   = 4,
  parameter int PcWidth = 32
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               pred_valid_i,
  output logic               pred_ready_o,
  input  logic [PcWidth-1:0] pred_pc_i,
  input  logic               pred_taken_i,
  input  logic [PcWidth-1:0] pred_target_i,
  input  logic               ex_valid_i,
  input  logic [PcWidth-1:0] ex_pc_i,
  input  logic               ex_taken_i,
  input  logic [PcWidth-1:0] ex_target_i,
  input  logic               flush_i,
  output logic               ex_br_valid_o,
  output logic [PcWidth-1:0] ex_br_instr_addr_o,
  output logic               ex_br_taken_o,
  output logic               mispredict_o,
  output logic [PcWidth-1:0] redirect_pc_o,
  output logic [31:0]        branch_cnt_o,
  output logic [31:0]        mispredict_cnt_o
);

  localparam int AW = $clog2(Depth);

  // FIFO storage. It has no reset, because the pointers alone define
  // which entries are valid.
  logic [PcWidth-1:0] r_fifo_pc  [Depth];
  logic [PcWidth-1:0] r_fifo_tgt [Depth];
  logic [Depth-1:0]   r_fifo_taken;

  // Each pointer carries one extra wrap bit. Equal pointers mean empty.
  // Pointers whose wrap bits differ but whose indices match mean full.
  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;

  logic [AW-1:0]      w_head_idx;
  logic [AW-1:0]      w_tail_idx;
  logic               w_empty;
  logic               w_full;
  logic               w_pop;
  logic               w_push;
  logic               w_pred_taken;
  logic [PcWidth-1:0] w_pred_target;
  logic               w_mispredict;
  logic               w_clear;
  logic [PcWidth-1:0] w_redirect_pc;

  assign w_head_idx = r_rd_ptr[AW-1:0];
  assign w_tail_idx = r_wr_ptr[AW-1:0];
  assign w_empty    = (r_wr_ptr == r_rd_ptr);
  assign w_full     = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                      (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

  // The head is consumed only when its PC matches the resolved PC. A
  // resolution that finds no match is judged against a not-taken prediction.
  assign w_pop         = ex_valid_i && !w_empty && (r_fifo_pc[w_head_idx] == ex_pc_i);
  assign w_pred_taken  = w_pop && r_fifo_taken[w_head_idx];
  assign w_pred_target = r_fifo_tgt[w_head_idx];

  // A taken/taken pair still mispredicts when the two targets differ.
  assign w_mispredict  = ex_valid_i &&
                         ((w_pred_taken != ex_taken_i) ||
                          (w_pred_taken && ex_taken_i && (w_pred_target != ex_target_i)));

  // The fall-through step is fixed at +4. Compressed instructions are handled
  // by EX.
  assign w_redirect_pc = ex_taken_i ? ex_target_i : (ex_pc_i + PcWidth'(4));

  // A pop in the same cycle frees a slot, so a full FIFO can still accept.
  assign pred_ready_o = !w_full || w_pop;

  // After a mispredict or a flush, every remaining entry is on the wrong path.
  assign w_clear = w_mispredict || flush_i;
  assign w_push  = pred_valid_i && pred_ready_o && !w_clear;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (w_clear) begin
      r_rd_ptr <= r_wr_ptr;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // When full with a pop in the same cycle, the tail slot is the head slot.
  // The head is read combinationally before this edge overwrites it.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_fifo_pc[w_tail_idx]    <= pred_pc_i;
      r_fifo_tgt[w_tail_idx]   <= pred_target_i;
      r_fifo_taken[w_tail_idx] <= pred_taken_i;
    end
  end

  // Registered outputs. Each is valid for exactly one cycle after ex_valid_i
  // and returns to zero otherwise.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ex_br_valid_o      <= 1'b0;
      ex_br_instr_addr_o <= '0;
      ex_br_taken_o      <= 1'b0;
      mispredict_o       <= 1'b0;
      redirect_pc_o      <= '0;
    end else begin
      ex_br_valid_o      <= ex_valid_i;
      ex_br_instr_addr_o <= ex_valid_i ? ex_pc_i : '0;
      ex_br_taken_o      <= ex_valid_i && ex_taken_i;
      // A flush overrides the redirect. The training update still goes out.
      mispredict_o       <= w_mispredict && !flush_i;
      redirect_pc_o      <= ex_valid_i ? w_redirect_pc : '0;
    end
  end

`ifdef BP_STATS_EN
  logic [31:0] r_branch_cnt;
  logic [31:0] r_mispredict_cnt;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_branch_cnt     <= '0;
      r_mispredict_cnt <= '0;
    end else begin
      if (ex_valid_i && (r_branch_cnt != 32'hFFFF_FFFF))
        r_branch_cnt <= r_branch_cnt + 32'd1;
      if (w_mispredict && !flush_i && (r_mispredict_cnt != 32'hFFFF_FFFF))
        r_mispredict_cnt <= r_mispredict_cnt + 32'd1;
    end
  end

  assign branch_cnt_o     = r_branch_cnt;
  assign mispredict_cnt_o = r_mispredict_cnt;
`else
  assign branch_cnt_o     = 32'h0;
  assign mispredict_cnt_o = 32'h0;
`endif

endmodule

// File: tb/tb_bp_resolve_unit.sv
// -----------------------------------------------------------------------------
// tb_bp_resolve_unit
//
// Directed test of bp_resolve_unit. The driver pushes a hand-computed
// expected training/redirect record for every ex_valid_i it issues. A monitor
// samples the outputs on the falling edge, pops a record whenever
// ex_br_valid_o is high, and otherwise checks that all outputs are idle.
// -----------------------------------------------------------------------------
module tb_bp_resolve_unit;

  localparam int PW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          pred_valid;
  logic          pred_ready;
  logic [PW-1:0] pred_pc;
  logic          pred_taken;
  logic [PW-1:0] pred_target;
  logic          ex_valid;
  logic [PW-1:0] ex_pc;
  logic          ex_taken;
  logic [PW-1:0] ex_target;
  logic          flush;
  logic          br_valid;
  logic [PW-1:0] br_addr;
  logic          br_taken;
  logic          mispredict;
  logic [PW-1:0] redirect_pc;
  logic [31:0]   branch_cnt;
  logic [31:0]   mispredict_cnt;

  // Record layout: {taken, addr, mispredict, redirect}.
  logic [65:0] exp_q[$];
  int          n_compared   = 0;
  int          n_mismatched = 0;
  logic [31:0] exp_br_cnt   = 0;
  logic [31:0] exp_mis_cnt  = 0;

  bp_resolve_unit #(.Depth(4), .PcWidth(PW)) dut (
    .clk_i              (clk),
    .rst_ni             (rst_n),
    .pred_valid_i       (pred_valid),
    .pred_ready_o       (pred_ready),
    .pred_pc_i          (pred_pc),
    .pred_taken_i       (pred_taken),
    .pred_target_i      (pred_target),
    .ex_valid_i         (ex_valid),
    .ex_pc_i            (ex_pc),
    .ex_taken_i         (ex_taken),
    .ex_target_i        (ex_target),
    .flush_i            (flush),
    .ex_br_valid_o      (br_valid),
    .ex_br_instr_addr_o (br_addr),
    .ex_br_taken_o      (br_taken),
    .mispredict_o       (mispredict),
    .redirect_pc_o      (redirect_pc),
    .branch_cnt_o       (branch_cnt),
    .mispredict_cnt_o   (mispredict_cnt)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [65:0] e;
    if (br_valid === 1'b1) begin
      n_compared++;
      if (exp_q.size() == 0) begin
        n_mismatched++;
        $display("FAIL unexpected_update: addr=0x%0h taken=%0b mis=%0b redir=0x%0h with no expected entry",
                 br_addr, br_taken, mispredict, redirect_pc);
      end else begin
        e = exp_q.pop_front();
        if ({br_taken, br_addr, mispredict, redirect_pc} !== e) begin
          n_mismatched++;
          $display("FAIL update: got taken=%0b addr=0x%0h mis=%0b redir=0x%0h expected taken=%0b addr=0x%0h mis=%0b redir=0x%0h",
                   br_taken, br_addr, mispredict, redirect_pc,
                   e[65], e[64:33], e[32], e[31:0]);
        end
      end
    end else begin
      n_compared++;
      if ((br_valid !== 1'b0) || (br_addr !== '0) || (br_taken !== 1'b0) ||
          (mispredict !== 1'b0) || (redirect_pc !== '0)) begin
        n_mismatched++;
        $display("FAIL idle_outputs: got valid=%0b addr=0x%0h taken=%0b mis=%0b redir=0x%0h expected all 0",
                 br_valid, br_addr, br_taken, mispredict, redirect_pc);
      end
    end
  end

  // ---------------- driver ----------------
  task automatic idle_inputs();
    pred_valid = 0; pred_pc = '0; pred_taken = 0; pred_target = '0;
    ex_valid = 0; ex_pc = '0; ex_taken = 0; ex_target = '0; flush = 0;
  endtask

  // Drives one cycle. chk_rdy >= 0 checks pred_ready before the edge.
  task automatic do_cycle(input logic pv, input logic [PW-1:0] ppc, input logic pt,
                          input logic [PW-1:0] ptgt, input logic ev, input logic [PW-1:0] epc,
                          input logic et, input logic [PW-1:0] etgt, input logic fl,
                          input logic exp_mis, input logic [PW-1:0] exp_redir,
                          input int chk_rdy);
    pred_valid = pv; pred_pc = ppc; pred_taken = pt; pred_target = ptgt;
    ex_valid = ev; ex_pc = epc; ex_taken = et; ex_target = etgt; flush = fl;
    if (ev) begin
      exp_q.push_back({et, epc, exp_mis, exp_redir});
      exp_br_cnt++;
      if (exp_mis) exp_mis_cnt++;
    end
    #1;
    if (chk_rdy >= 0) check("ready_same_cycle", {31'b0, pred_ready}, chk_rdy);
    @(posedge clk); #1;
    idle_inputs();
  endtask

  task automatic push_pred(input logic [PW-1:0] pc, input logic t, input logic [PW-1:0] tgt);
    do_cycle(1, pc, t, tgt, 0, '0, 0, '0, 0, 0, '0, -1);
  endtask

  task automatic resolve(input logic [PW-1:0] pc, input logic t, input logic [PW-1:0] tgt,
                         input logic mis, input logic [PW-1:0] redir);
    do_cycle(0, '0, 0, '0, 1, pc, t, tgt, 0, mis, redir, -1);
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
  endtask

  task automatic check_counters(input string name);
`ifdef BP_STATS_EN
    check({name, "_branch_cnt"}, branch_cnt, exp_br_cnt);
    check({name, "_mispredict_cnt"}, mispredict_cnt, exp_mis_cnt);
`else
    check({name, "_branch_cnt"}, branch_cnt, 32'h0);
    check({name, "_mispredict_cnt"}, mispredict_cnt, 32'h0);
`endif
  endtask

  // ---------------- stimulus ----------------
  initial begin
    idle_inputs();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_ready", {31'b0, pred_ready}, 1);
    check("reset_br_valid", {31'b0, br_valid}, 0);
    check("reset_mispredict", {31'b0, mispredict}, 0);
    check_counters("reset");
    rst_n = 1;
    idle_cycle();

    // 1: correct taken prediction
    push_pred(32'h100, 1, 32'h140);
    resolve(32'h100, 1, 32'h140, 0, 32'h140);
    check("t1_ready_empty", {31'b0, pred_ready}, 1);

    // 2: predicted not-taken, actually taken
    push_pred(32'h200, 0, '0);
    resolve(32'h200, 1, 32'h180, 1, 32'h180);

    // 3: fill the FIFO, then push and pop in the same cycle while full
    push_pred(32'h10, 0, '0);
    push_pred(32'h14, 0, '0);
    push_pred(32'h18, 0, '0);
    push_pred(32'h1C, 0, '0);
    check("t3_full_not_ready", {31'b0, pred_ready}, 0);
    do_cycle(1, 32'h20, 1, 32'h80, 1, 32'h10, 0, '0, 0, 0, 32'h14, 1);
    check("t3_still_full", {31'b0, pred_ready}, 0);
    resolve(32'h14, 0, '0, 0, 32'h18);
    resolve(32'h18, 0, '0, 0, 32'h1C);
    resolve(32'h1C, 0, '0, 0, 32'h20);
    resolve(32'h20, 1, 32'h80, 0, 32'h80);   // only correct if the 5th push was stored
    check("t3_drained_ready", {31'b0, pred_ready}, 1);

    // 4: a mispredict clears the younger entries
    push_pred(32'h300, 0, '0);
    push_pred(32'h304, 1, 32'h500);
    push_pred(32'h308, 0, '0);
    resolve(32'h300, 1, 32'h360, 1, 32'h360);
    resolve(32'h304, 1, 32'h500, 1, 32'h500);  // unmatched: judged as not-taken

    // 5: resolution with an empty FIFO
    resolve(32'h400, 1, 32'h480, 1, 32'h480);

    // Both taken, but the targets differ
    push_pred(32'h600, 1, 32'h700);
    resolve(32'h600, 1, 32'h780, 1, 32'h780);

    // A push in the mispredicting cycle is dropped
    push_pred(32'h610, 0, '0);
    do_cycle(1, 32'h630, 1, 32'h640, 1, 32'h610, 1, 32'h620, 0, 1, 32'h620, -1);
    resolve(32'h630, 1, 32'h640, 1, 32'h640);

    // 6: flush with a same-cycle mismatching resolution and a push
    push_pred(32'h700, 1, 32'h740);
    check_counters("pre_flush");
    do_cycle(1, 32'h710, 1, 32'h720, 1, 32'h900, 1, 32'h980, 1, 0, 32'h980, -1);
    check_counters("post_flush");
    resolve(32'h700, 1, 32'h740, 1, 32'h740);  // FIFO was flushed
    resolve(32'h710, 1, 32'h720, 1, 32'h720);  // the push was dropped
    idle_cycle();
    check_counters("pre_reset");

    // Reset mid-run: the stored entry is discarded, and an ex_valid_i
    // during reset produces nothing
    push_pred(32'h800, 1, 32'h840);
    rst_n = 0;
    ex_valid = 1; ex_pc = 32'h800; ex_taken = 1; ex_target = 32'h840;
    @(posedge clk); #1;
    idle_inputs();
    check("midreset_ready", {31'b0, pred_ready}, 1);
    check("midreset_mispredict", {31'b0, mispredict}, 0);
    check("midreset_redirect", redirect_pc, 0);
    exp_br_cnt = 0;
    exp_mis_cnt = 0;
    check_counters("midreset");
    rst_n = 1;
    idle_cycle();
    resolve(32'h800, 1, 32'h840, 1, 32'h840);
    idle_cycle();
    idle_cycle();
    check_counters("final");
    check("scoreboard_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
